// File: rtl/glb_port_arbiter.sv
// glb_port_arbiter: shares one single-port GLB SRAM bank between the DRAM
// loader (0), the systolic-array reader (1) and the PPU (2). Round-robin
// arbitration with a burst lock, registered SRAM commands and a tagged,
// two-cycle read-return pipeline.
//
// Handshake: a requester raises req[i] with lock/we/addr/wdata valid and holds
// them stable until it observes gnt[i]=1 in the same cycle; every cycle with
// gnt[i]=1 consumes exactly one access. Read data comes back as rvalid[i]
// (one-cycle pulse) with rdata, two clock edges after the granting cycle.
module glb_port_arbiter #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2:0]          req,
  input  logic [2:0]          lock,
  input  logic [2:0]          we,
  input  logic [3*ADDR_W-1:0] addr,
  input  logic [3*DATA_W-1:0] wdata,
  output logic [2:0]          gnt,
  output logic [2:0]          rvalid,
  output logic [DATA_W-1:0]   rdata,
  output logic                sram_en,
  output logic                sram_we,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [DATA_W-1:0]   sram_wdata,
  input  logic [DATA_W-1:0]   sram_rdata
);

  localparam int CW = $clog2(MAX_BURST);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST - 1);

  // Requester index; NONE marks "no owner" / "no read in flight".
  typedef enum logic [1:0] {
    IDX_0    = 2'd0,
    IDX_1    = 2'd1,
    IDX_2    = 2'd2,
    IDX_NONE = 2'd3
  } idx_e;

  logic [1:0]        rr_ptr_q, rr_ptr_d;
  idx_e              owner_q, owner_d;
  logic [CW-1:0]     burst_cnt_q, burst_cnt_d;
  idx_e              rd_tag_q, rd_tag_d;
  logic              sram_en_q, sram_en_d;
  logic              sram_we_q, sram_we_d;
  logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic [DATA_W-1:0] sram_wdata_q, sram_wdata_d;
  logic [2:0]        rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [2:0]        own_vec;
  logic [2:0]        cand;
  logic              hold;
  logic              found;
  logic              any_gnt;
  idx_e              win;
  logic [1:0]        scan_idx;
  logic              win_we;
  logic              win_lock;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  // Winner selection: locked owner keeps the bank until its burst limit; at
  // the limit it is dropped from the scan only when someone else is waiting.
  always_comb begin
    own_vec  = (owner_q == IDX_NONE) ? 3'b000 : (3'b001 << owner_q);
    cand     = req;
    hold     = 1'b0;
    found    = 1'b0;
    win      = IDX_0;
    scan_idx = 2'd0;
    if (|(own_vec & req & lock) && (burst_cnt_q != CNT_MAX)) begin
      hold = 1'b1;
    end else if (|(own_vec & req) && (burst_cnt_q == CNT_MAX) && |(req & ~own_vec)) begin
      cand = req & ~own_vec;
    end
    if (hold) begin
      found = 1'b1;
      win   = owner_q;
    end else begin
      for (int k = 0; k < 3; k++) begin
        scan_idx = 2'((int'(rr_ptr_q) + k) % 3);
        if (!found && cand[scan_idx]) begin
          found = 1'b1;
          win   = idx_e'(scan_idx);
        end
      end
    end
    any_gnt = found && !rst;
    gnt     = any_gnt ? (3'b001 << win) : 3'b000;
  end

  // Winner's command fields.
  always_comb begin
    win_we    = 1'b0;
    win_lock  = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    case (win)
      IDX_0: begin
        win_we    = we[0];
        win_lock  = lock[0];
        win_addr  = addr[0*ADDR_W +: ADDR_W];
        win_wdata = wdata[0*DATA_W +: DATA_W];
      end
      IDX_1: begin
        win_we    = we[1];
        win_lock  = lock[1];
        win_addr  = addr[1*ADDR_W +: ADDR_W];
        win_wdata = wdata[1*DATA_W +: DATA_W];
      end
      IDX_2: begin
        win_we    = we[2];
        win_lock  = lock[2];
        win_addr  = addr[2*ADDR_W +: ADDR_W];
        win_wdata = wdata[2*DATA_W +: DATA_W];
      end
      default: begin
        win_we    = 1'b0;
        win_lock  = 1'b0;
        win_addr  = '0;
        win_wdata = '0;
      end
    endcase
  end

  // Arbitration state: rotate priority on every grant, track burst ownership.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    if (any_gnt) begin
      rr_ptr_d = (win == IDX_2) ? 2'd0 : (2'(win) + 2'd1);
      if (win_lock) begin
        if (owner_q == win) begin
          burst_cnt_d = burst_cnt_q + CW'(1);
        end else begin
          owner_d     = win;
          burst_cnt_d = '0;
        end
      end else begin
        owner_d     = IDX_NONE;
        burst_cnt_d = '0;
      end
    end else begin
      owner_d     = IDX_NONE;
      burst_cnt_d = '0;
    end
  end

  // Command and read-return pipeline: issue at +1, return data at +2.
  always_comb begin
    sram_en_d    = any_gnt;
    sram_we_d    = sram_we_q;
    sram_addr_d  = sram_addr_q;
    sram_wdata_d = sram_wdata_q;
    rd_tag_d     = IDX_NONE;
    rvalid_d     = 3'b000;
    rdata_d      = rdata_q;
    if (any_gnt) begin
      sram_we_d    = win_we;
      sram_addr_d  = win_addr;
      sram_wdata_d = win_wdata;
      if (!win_we) begin
        rd_tag_d = win;
      end
    end
    if (rd_tag_q != IDX_NONE) begin
      rvalid_d = 3'b001 << rd_tag_q;
      rdata_d  = sram_rdata;
    end
  end

  // State registers; reset discards any in-flight read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q     <= 2'd0;
      owner_q      <= IDX_NONE;
      burst_cnt_q  <= '0;
      rd_tag_q     <= IDX_NONE;
      sram_en_q    <= 1'b0;
      sram_we_q    <= 1'b0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
      rvalid_q     <= 3'b000;
      rdata_q      <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      owner_q      <= owner_d;
      burst_cnt_q  <= burst_cnt_d;
      rd_tag_q     <= rd_tag_d;
      sram_en_q    <= sram_en_d;
      sram_we_q    <= sram_we_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
    end
  end

  assign sram_en    = sram_en_q;
  assign sram_we    = sram_we_q;
  assign sram_addr  = sram_addr_q;
  assign sram_wdata = sram_wdata_q;
  assign rvalid     = rvalid_q;
  assign rdata      = rdata_q;

endmodule

// File: tb/tb_glb_port_arbiter.sv
// Testbench for glb_port_arbiter: directed vectors, expected SRAM commands and
// read returns queued at issue time and compared by an independent monitor.
module tb_glb_port_arbiter;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int MB = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT hookup ----------------
  logic [2:0]      req, lock, we;
  logic [AW-1:0]   a_v [3];
  logic [DW-1:0]   d_v [3];
  logic [3*AW-1:0] addr;
  logic [3*DW-1:0] wdata;
  logic [2:0]      gnt, rvalid;
  logic [DW-1:0]   rdata;
  logic            sram_en, sram_we;
  logic [AW-1:0]   sram_addr;
  logic [DW-1:0]   sram_wdata, sram_rdata;

  assign addr  = {a_v[2], a_v[1], a_v[0]};
  assign wdata = {d_v[2], d_v[1], d_v[0]};

  glb_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .lock       (lock),
    .we         (we),
    .addr       (addr),
    .wdata      (wdata),
    .gnt        (gnt),
    .rvalid     (rvalid),
    .rdata      (rdata),
    .sram_en    (sram_en),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  // SRAM bank model: writes land on the clock edge, read data flows through
  // from the registered address so it is ready at the next edge.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'hA000_0000 | i;
    mem[5] = 32'hDEAD_BEEF;
    forever begin
      @(posedge clk);
      if (sram_en && sram_we) mem[sram_addr] <= sram_wdata;
    end
  end
  assign sram_rdata = mem[sram_addr];

  // ---------------- scoreboard ----------------
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  logic [60:0]   cmd_q[$];   // {due, we, addr, wdata}
  logic [50:0]   exp_q[$];   // {due, rvalid onehot, rdata}
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got=%h exp=%h", nm, cyc, got, exp);
  endtask

  // Monitor: compare registered outputs just after each edge.
  always @(posedge clk) begin
    logic [60:0] c;
    logic [50:0] e;
    #1;
    if (cmd_q.size() > 0 && cmd_q[0][60:45] == cyc[15:0]) begin
      c = cmd_q.pop_front();
      chk("sram_en", {63'd0, sram_en}, 64'd1);
      chk("sram_we", {63'd0, sram_we}, {63'd0, c[44]});
      chk("sram_addr", {52'd0, sram_addr}, {52'd0, c[43:32]});
      chk("sram_wdata", {32'd0, sram_wdata}, {32'd0, c[31:0]});
    end else begin
      chk("sram_en idle", {63'd0, sram_en}, 64'd0);
    end
    if (exp_q.size() > 0 && exp_q[0][50:35] == cyc[15:0]) begin
      e = exp_q.pop_front();
      chk("rvalid", {61'd0, rvalid}, {61'd0, e[34:32]});
      chk("rdata", {32'd0, rdata}, {32'd0, e[31:0]});
    end else begin
      chk("rvalid idle", {61'd0, rvalid}, 64'd0);
    end
  end

  // ---------------- driver tasks ----------------
  // Inputs are set at the falling edge; the grant is checked 1 time unit later
  // and the expected SRAM command and read return are queued.
  task automatic tick(input string nm, input logic [2:0] exp_gnt);
    #1;
    chk({nm, " gnt"}, {61'd0, gnt}, {61'd0, exp_gnt});
    for (int i = 0; i < 3; i++) begin
      if (exp_gnt[i]) begin
        cmd_q.push_back({16'(cyc + 1), we[i], a_v[i], d_v[i]});
        if (we[i]) ref_mem[a_v[i]] = d_v[i];
        else exp_q.push_back({16'(cyc + 2), 3'(3'b001 << i), ref_mem[a_v[i]]});
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req  = 3'b000;
    lock = 3'b000;
    we   = 3'b000;
    cmd_q.delete();
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain(input int n);
    req  = 3'b000;
    lock = 3'b000;
    repeat (n) tick("drain", 3'b000);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int idx0;
    logic [2:0] eg;
    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = 32'hA000_0000 | i;
    ref_mem[5] = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      a_v[i] = '0;
      d_v[i] = '0;
    end

    // Reset state: grant forced low even with every request raised.
    rst  = 1'b1;
    req  = 3'b111;
    lock = 3'b000;
    we   = 3'b000;
    #2;
    chk("reset gnt", {61'd0, gnt}, 64'd0);
    chk("reset rdata", {32'd0, rdata}, 64'd0);
    do_reset();

    // Idle then a single read of the preloaded word.
    repeat (10) tick("idle", 3'b000);
    req = 3'b010; we = 3'b000; a_v[1] = 12'h005; d_v[1] = 32'h0;
    tick("single rd", 3'b010);
    drain(3);

    // Round-robin fairness straight after reset.
    do_reset();
    req = 3'b111; we = 3'b000; lock = 3'b000;
    a_v[0] = 12'h010; a_v[1] = 12'h020; a_v[2] = 12'h030;
    d_v[0] = 32'h0;   d_v[1] = 32'h0;   d_v[2] = 32'h0;
    for (int k = 0; k < 6; k++) tick("rr", 3'(3'b001 << (k % 3)));
    drain(3);

    // Burst lock on requester 0 with forced rotation to requester 2.
    do_reset();
    req = 3'b101; lock = 3'b001; we = 3'b001;
    a_v[2] = 12'h300; d_v[2] = 32'h0;
    idx0 = 0;
    for (int k = 0; k < 21; k++) begin
      a_v[0] = 12'(idx0);
      d_v[0] = 32'h1000_0000 + 32'(idx0);
      eg = (k == 16) ? 3'b100 : 3'b001;
      tick("burst", eg);
      if (eg[0]) idx0++;
      if (k == 16) req[2] = 1'b0;
    end
    drain(3);

    // Sole locked requester: no bubble when the burst counter wraps.
    req = 3'b010; lock = 3'b010; we = 3'b000;
    for (int k = 0; k < 40; k++) begin
      a_v[1] = 12'(k);
      tick("sole lock", 3'b010);
    end
    drain(3);

    // Write then read of the same address in consecutive grants.
    req = 3'b001; we = 3'b001; a_v[0] = 12'h0A0; d_v[0] = 32'h1234_5678;
    tick("wr A0", 3'b001);
    req = 3'b010; we = 3'b000; a_v[1] = 12'h0A0;
    tick("rd A0", 3'b010);
    drain(3);

    // Async reset between edges while a read is in flight.
    req = 3'b010; we = 3'b000; a_v[1] = 12'h005;
    tick("pre-rst rd", 3'b010);
    rst = 1'b1;
    cmd_q.delete();
    exp_q.delete();
    req = 3'b111;
    #1;
    chk("midrst gnt", {61'd0, gnt}, 64'd0);
    chk("midrst sram_en", {63'd0, sram_en}, 64'd0);
    chk("midrst sram_we", {63'd0, sram_we}, 64'd0);
    chk("midrst sram_addr", {52'd0, sram_addr}, 64'd0);
    chk("midrst sram_wdata", {32'd0, sram_wdata}, 64'd0);
    chk("midrst rvalid", {61'd0, rvalid}, 64'd0);
    chk("midrst rdata", {32'd0, rdata}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    we = 3'b000; lock = 3'b000;
    a_v[0] = 12'h040; a_v[1] = 12'h041; a_v[2] = 12'h042;
    tick("post-rst rr", 3'b001);
    tick("post-rst rr", 3'b010);
    tick("post-rst rr", 3'b100);
    drain(4);

    chk("cmd queue empty", 64'(cmd_q.size()), 64'd0);
    chk("rd queue empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/glb_port_arbiter.md
Name: glb_port_arbiter

Overview:
Shares one single-port GLB SRAM bank between three requesters: 0 = DRAM loader (writes ifmap/weight/bias), 1 = systolic-array reader, 2 = PPU (ofmap read/write).
Round-robin arbitration with optional burst lock, so each requester can stream consecutive addresses.
SRAM commands are registered. Read data returns to the winning requester tagged with rvalid.
Sits between the top-level Controller-driven requesters and the GLB macro.

Parameters:
ADDR_W, 12, GLB word address width
DATA_W, 32, GLB word width
MAX_BURST, 16, maximum consecutive grants to one locked requester before forced rotation (power of 2, at least 2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
req  in  3  per-requester access request, bit i = requester i
lock  in  3  per-requester burst-lock hint; only meaningful while req[i]=1
we  in  3  per-requester write enable (1 = write, 0 = read)
addr  in  3*ADDR_W  per-requester address, slice i = [i*ADDR_W +: ADDR_W]
wdata  in  3*DATA_W  per-requester write data, same slicing
gnt  out  3  one-hot-or-zero grant, combinational
rvalid  out  3  read data valid for requester i, registered
rdata  out  DATA_W  read data, shared by all requesters, qualified by rvalid
sram_en  out  1  SRAM access enable, registered
sram_we  out  1  SRAM write enable, registered
sram_addr  out  ADDR_W  SRAM address, registered
sram_wdata  out  DATA_W  SRAM write data, registered
sram_rdata  in  DATA_W  SRAM read data, valid 1 cycle after sram_en with sram_we=0

Behaviour:
- Reset (async, rst=1):
  - rr_ptr=0, owner=NONE, burst_cnt=0.
  - sram_en=0, sram_we=0, sram_addr=0, sram_wdata=0.
  - rvalid=0, rdata=0, rd_tag=NONE.
  - gnt is forced to 3'b000 while rst=1.
- Internal state:
  - rr_ptr (2b, values 0..2): index with highest priority.
  - owner (NONE/0/1/2): current locked holder.
  - burst_cnt (log2(MAX_BURST) bits).
- Grant (combinational, evaluated every cycle):
  - Locked case: if owner=i, req[i]=1, lock[i]=1 and burst_cnt<MAX_BURST-1, then gnt[i]=1.
  - Otherwise: grant the first requester with req set, scanning cyclically from rr_ptr (rr_ptr, rr_ptr+1, rr_ptr+2 mod 3).
  - No req set: gnt=0.
  - A requester holds its command stable until it sees gnt=1; each gnt cycle consumes exactly one access.
- State update on a grant to i:
  - If lock[i]=1 and owner=i: burst_cnt++.
  - If lock[i]=1 and owner!=i: owner=i, burst_cnt=0.
  - If lock[i]=0: owner=NONE, burst_cnt=0.
  - rr_ptr = (i+1) mod 3 on every grant, so priority rotates as soon as the lock drops.
- Forced rotation:
  - Condition: owner=i, burst_cnt=MAX_BURST-1, req[i]=1.
  - i is excluded from that cycle's scan only if another req is set.
  - On rotation, owner becomes the new grantee (if it locks) or NONE; burst_cnt=0.
  - A sole requester keeps the grant and burst_cnt wraps to 0.
- Lock release:
  - owner with req[i]=0 or lock[i]=0: normal round-robin applies, owner cleared at the next grant.
  - No grant that cycle: owner=NONE, burst_cnt=0.
- Command pipeline:
  - Grant in cycle T: sram_en=1, sram_we/addr/wdata = winner's fields at T+1.
  - No grant: sram_en=0 at T+1, other SRAM outputs hold.
- Read return:
  - Granted read at T: rd_tag captured at T+1.
  - At T+2: rvalid[tag]=1 for one cycle and rdata<=sram_rdata (latched, holds until the next read return).
  - Writes produce no rvalid.
  - Back-to-back reads give one rvalid per cycle, 2-cycle latency, fully pipelined.
  - A read and a write to the same address in consecutive grants execute in grant order; no forwarding.
- Simultaneous events: all three req set with no owner, so the grant order is strictly rr_ptr, rr_ptr+1, rr_ptr+2.
- Reset mid-operation: in-flight reads are discarded (rvalid=0), and no SRAM access is issued in the cycle after reset release.
- Throughput: one access per cycle whenever any req=1.

Test Plan:
- Reset and idle: rst pulse, req=0. Check gnt=0, sram_en=0, rvalid=0 for 10 cycles. Then req[1]=1 read addr 0x005 (SRAM preloaded 0xDEADBEEF) -> gnt[1] same cycle, sram_en/addr=0x005 next cycle, rvalid[1]=1 with rdata=0xDEADBEEF 2 cycles after gnt.
- Round-robin fairness: req=3'b111, lock=0, all reads, 6 cycles after reset -> gnt sequence 001,010,100,001,010,100; rvalid bits follow the same order 2 cycles later.
- Burst lock with forced rotation: MAX_BURST=16, req[0] lock=1 writing addrs 0..19, req[2] read pending -> 16 consecutive gnt[0], then gnt[2], then gnt[0] resumes at addr 16 with burst_cnt=0.
- Sole locked requester: only req[1] lock=1 for 40 cycles -> gnt[1] all 40 cycles, no bubble at the burst_cnt wrap.
- Write/read ordering: gnt[0] writes 0x12345678 to 0x0A0, next cycle gnt[1] reads 0x0A0 -> rvalid[1] returns 0x12345678.
- Async reset mid-read: read granted at T, rst asserted between edges at T+1 -> rvalid stays 0, all SRAM outputs 0 immediately, rr_ptr=0 after release.
